// File: rtl/comp_row_scheduler.sv
// rtl/comp_row_scheduler.sv - records compensation rows per column and sequences activation reads
// Define COMP_SCHED_STATS_EN to add the issue_cnt/stall_cnt pass statistics outputs.
module comp_row_scheduler #(
   parameter int NUM_COL = 8,
   parameter int SLOTS   = 3,
   parameter int NUM_VEC = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  comp_row,
   input  logic        comp_valid,
   input  logic        change_col,
   input  logic        load_done,
   input  logic        start,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [5:0]  out_addr,
   output logic [2:0]  out_col,
   output logic [2:0]  out_row,
   output logic        out_last,
   output logic        sched_done,
   output logic        busy,
`ifdef COMP_SCHED_STATS_EN
   output logic [8:0]  issue_cnt,
   output logic [15:0] stall_cnt,
`endif
   output logic        overflow_err
);
   typedef enum logic [1:0] {COLLECT, READY, RUN, DONE} state_t;

   state_t                             state_q, state_d;
   logic [NUM_COL-1:0][SLOTS-1:0][2:0] rows_q, rows_d;
   logic [NUM_COL-1:0][SLOTS-1:0]      vld_q, vld_d;
   logic [3:0] col_ptr_q, col_ptr_d;
   logic [1:0] slot_ptr_q, slot_ptr_d;
   logic       it_ok_q, it_ok_d;
   logic [2:0] it_c_q, it_c_d, it_k_q, it_k_d;
   logic [1:0] it_s_q, it_s_d;
   logic       out_valid_q, out_valid_d, out_last_q, out_last_d, ovf_q, ovf_d;
   logic [5:0] out_addr_q, out_addr_d;
   logic [2:0] out_col_q, out_col_d, out_row_q, out_row_d;
`ifdef COMP_SCHED_STATS_EN
   logic [8:0]  issue_q, issue_d;
   logic [15:0] stall_q, stall_d;
`endif

   logic [NUM_COL-1:0]      col_has;
   logic [NUM_COL-1:0][1:0] first_s;
   logic [2:0] first_col, cur_c, cur_k, col_nxt, succ_c, succ_k;
   logic [1:0] cur_s, slot_nxt, succ_s;
   logic       cur_ok, slot_hit, col_hit, succ_ok;

   always_comb begin
      for (int c = 0; c < NUM_COL; c++) begin
         col_has[c] = |vld_q[c];
         first_s[c] = '0;
         for (int s = SLOTS - 1; s >= 0; s--)
            if (vld_q[c][s]) first_s[c] = 2'(s);
      end
   end

   // cur_* is the transaction to load next: the table head when starting, else the iterator.
   always_comb begin
      first_col = '0;
      for (int c = NUM_COL - 1; c >= 0; c--)
         if (col_has[c]) first_col = 3'(c);
      if (state_q == READY) begin
         cur_ok = |col_has;
         cur_c  = first_col;
         cur_k  = '0;
         cur_s  = first_s[first_col];
      end else begin
         cur_ok = it_ok_q;
         cur_c  = it_c_q;
         cur_k  = it_k_q;
         cur_s  = it_s_q;
      end
      slot_hit = 1'b0;
      slot_nxt = cur_s;
      for (int s = SLOTS - 1; s >= 0; s--)
         if (s > int'(cur_s) && vld_q[cur_c][s]) begin
            slot_hit = 1'b1;
            slot_nxt = 2'(s);
         end
      col_hit = 1'b0;
      col_nxt = cur_c;
      for (int c = NUM_COL - 1; c >= 0; c--)
         if (c > int'(cur_c) && col_has[c]) begin
            col_hit = 1'b1;
            col_nxt = 3'(c);
         end
      succ_ok = 1'b1;
      succ_c  = cur_c;
      succ_k  = cur_k;
      succ_s  = cur_s;
      if (slot_hit) begin
         succ_s = slot_nxt;
      end else if (cur_k != 3'(NUM_VEC - 1)) begin
         succ_k = cur_k + 3'd1;
         succ_s = first_s[cur_c];
      end else if (col_hit) begin
         succ_c = col_nxt;
         succ_k = '0;
         succ_s = first_s[col_nxt];
      end else begin
         succ_ok = 1'b0;
      end
   end

   always_comb begin
      state_d     = state_q;
      rows_d      = rows_q;
      vld_d       = vld_q;
      col_ptr_d   = col_ptr_q;
      slot_ptr_d  = slot_ptr_q;
      it_ok_d     = it_ok_q;
      it_c_d      = it_c_q;
      it_k_d      = it_k_q;
      it_s_d      = it_s_q;
      out_valid_d = out_valid_q;
      out_addr_d  = out_addr_q;
      out_col_d   = out_col_q;
      out_row_d   = out_row_q;
      out_last_d  = out_last_q;
      ovf_d       = ovf_q;
`ifdef COMP_SCHED_STATS_EN
      issue_d     = issue_q;
      stall_d     = stall_q;
`endif
      case (state_q)
         COLLECT: begin
            if (comp_valid) begin
               if (slot_ptr_q < 2'(SLOTS) && col_ptr_q < 4'(NUM_COL)) begin
                  rows_d[col_ptr_q[2:0]][slot_ptr_q] = comp_row;
                  vld_d[col_ptr_q[2:0]][slot_ptr_q]  = 1'b1;
                  slot_ptr_d = slot_ptr_q + 2'd1;
               end else begin
                  ovf_d = 1'b1;
               end
            end
            if (change_col) begin
               if (col_ptr_q < 4'(NUM_COL)) col_ptr_d = col_ptr_q + 4'd1;
               slot_ptr_d = '0;
            end
            if (load_done) state_d = READY;
         end
         READY: begin
            if (start) begin
               state_d = RUN;
`ifdef COMP_SCHED_STATS_EN
               issue_d = '0;
               stall_d = '0;
`endif
            end
         end
         RUN: begin
`ifdef COMP_SCHED_STATS_EN
            if (out_valid_q && out_ready) issue_d = issue_q + 9'd1;
            if (out_valid_q && !out_ready && stall_q != 16'hffff) stall_d = stall_q + 16'd1;
`endif
            if (!cur_ok && (!out_valid_q || out_ready)) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               state_d     = DONE;
            end
         end
         default: begin
            vld_d      = '0;
            rows_d     = '0;
            col_ptr_d  = '0;
            slot_ptr_d = '0;
            state_d    = COLLECT;
         end
      endcase
      // Load the output register at start or whenever it is empty or being consumed.
      if (cur_ok && ((state_q == READY && start) || (state_q == RUN && (!out_valid_q || out_ready)))) begin
         out_valid_d = 1'b1;
         out_col_d   = cur_c;
         out_row_d   = rows_q[cur_c][cur_s];
         out_addr_d  = {cur_k, rows_q[cur_c][cur_s]};
         out_last_d  = !succ_ok;
         it_ok_d     = succ_ok;
         it_c_d      = succ_c;
         it_k_d      = succ_k;
         it_s_d      = succ_s;
      end else if (state_q == READY && start) begin
         it_ok_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= COLLECT;
         rows_q      <= '0;
         vld_q       <= '0;
         col_ptr_q   <= '0;
         slot_ptr_q  <= '0;
         it_ok_q     <= 1'b0;
         it_c_q      <= '0;
         it_k_q      <= '0;
         it_s_q      <= '0;
         out_valid_q <= 1'b0;
         out_addr_q  <= '0;
         out_col_q   <= '0;
         out_row_q   <= '0;
         out_last_q  <= 1'b0;
         ovf_q       <= 1'b0;
`ifdef COMP_SCHED_STATS_EN
         issue_q     <= '0;
         stall_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         rows_q      <= rows_d;
         vld_q       <= vld_d;
         col_ptr_q   <= col_ptr_d;
         slot_ptr_q  <= slot_ptr_d;
         it_ok_q     <= it_ok_d;
         it_c_q      <= it_c_d;
         it_k_q      <= it_k_d;
         it_s_q      <= it_s_d;
         out_valid_q <= out_valid_d;
         out_addr_q  <= out_addr_d;
         out_col_q   <= out_col_d;
         out_row_q   <= out_row_d;
         out_last_q  <= out_last_d;
         ovf_q       <= ovf_d;
`ifdef COMP_SCHED_STATS_EN
         issue_q     <= issue_d;
         stall_q     <= stall_d;
`endif
      end
   end

   assign out_valid    = out_valid_q;
   assign out_addr     = out_addr_q;
   assign out_col      = out_col_q;
   assign out_row      = out_row_q;
   assign out_last     = out_last_q;
   assign overflow_err = ovf_q;
   assign sched_done   = (state_q == DONE);
   assign busy         = (state_q == RUN);
`ifdef COMP_SCHED_STATS_EN
   assign issue_cnt    = issue_q;
   assign stall_cnt    = stall_q;
`endif
endmodule
